// File: rtl/parallel_serializer.sv
// -----------------------------------------------------------------------------
// parallel_serializer
//   Turns WIDTH-bit words into a stream of BITS_PER_SYMBOL-bit symbols, one
//   symbol per `next` strobe from the symbol-rate timer. A shift stage holds
//   the word being emitted and a one-word hold stage lets the next word be
//   queued, so consecutive words are sent with no gap.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_data      in   parallel word (WIDTH)
//   in_valid     in   in_data valid
//   in_ready     out  word taken on an edge where in_valid & in_ready
//   next         in   one-cycle symbol strobe
//   symbol_out   out  current symbol (BITS_PER_SYMBOL), registered
//   symbol_valid out  one-cycle pulse when symbol_out updates
//   last         out  with symbol_valid on the final symbol of a word
//   underrun     out  one-cycle pulse when `next` finds no word to send
//   busy         out  a word is in the shift or hold stage
// -----------------------------------------------------------------------------
module parallel_serializer #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned BITS_PER_SYMBOL = 1,
    parameter int unsigned MSB_FIRST       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       next,
    output logic [BITS_PER_SYMBOL-1:0] symbol_out,
    output logic                       symbol_valid,
    output logic                       last,
    output logic                       underrun,
    output logic                       busy
);

    localparam int unsigned SYMBOLS = WIDTH / BITS_PER_SYMBOL;
    localparam int unsigned CNT_W   = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
    localparam int unsigned IDX_W   = $clog2(WIDTH) + 1;

    // Storage and registered outputs
    logic [WIDTH-1:0]           r_shift_data;
    logic                       r_shift_full;
    logic [CNT_W-1:0]           r_cnt;
    logic [WIDTH-1:0]           r_hold_data;
    logic                       r_hold_full;
    logic [BITS_PER_SYMBOL-1:0] r_symbol;
    logic                       r_symbol_valid;
    logic                       r_last;
    logic                       r_underrun;
    logic                       r_busy;

    // Next-state values
    logic [WIDTH-1:0]           w_shift_data_nxt;
    logic                       w_shift_full_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [WIDTH-1:0]           w_hold_data_nxt;
    logic                       w_hold_full_nxt;
    logic [BITS_PER_SYMBOL-1:0] w_symbol_nxt;
    logic                       w_symbol_valid_nxt;
    logic                       w_last_nxt;
    logic                       w_underrun_nxt;

    logic                       w_accept;
    logic                       w_at_end;
    logic [IDX_W-1:0]           w_lo;
    logic [WIDTH-1:0]           w_shifted;
    logic [BITS_PER_SYMBOL-1:0] w_cur_symbol;

    // Ready only reflects hold-stage space; forced low while in reset
    assign in_ready = rst_n & ~r_hold_full;
    assign w_accept = in_valid & in_ready;
    assign w_at_end = (r_cnt == CNT_W'(SYMBOLS - 1));

    // Bit offset of the slice for counter k, counted from the word LSB
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_lo = IDX_W'(WIDTH - BITS_PER_SYMBOL)
                 - (IDX_W'(r_cnt) * IDX_W'(BITS_PER_SYMBOL));
        end else begin
            w_lo = IDX_W'(r_cnt) * IDX_W'(BITS_PER_SYMBOL);
        end
    end

    assign w_shifted    = r_shift_data >> w_lo;
    assign w_cur_symbol = w_shifted[BITS_PER_SYMBOL-1:0];

    // Next-state: emit on `next`, refill the shift stage at word end
    always_comb begin
        w_shift_data_nxt   = r_shift_data;
        w_shift_full_nxt   = r_shift_full;
        w_cnt_nxt          = r_cnt;
        w_hold_data_nxt    = r_hold_data;
        w_hold_full_nxt    = r_hold_full;
        w_symbol_nxt       = r_symbol;
        w_symbol_valid_nxt = 1'b0;
        w_last_nxt         = 1'b0;
        w_underrun_nxt     = 1'b0;

        if (r_shift_full) begin
            if (next) begin
                w_symbol_valid_nxt = 1'b1;
                w_symbol_nxt       = w_cur_symbol;
                if (w_at_end) begin
                    w_last_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    // Hold word has priority; a new word is only accepted
                    // here when the hold stage is empty
                    if (r_hold_full) begin
                        w_shift_data_nxt = r_hold_data;
                        w_hold_full_nxt  = 1'b0;
                    end else if (w_accept) begin
                        w_shift_data_nxt = in_data;
                    end else begin
                        w_shift_full_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_accept) begin
                        w_hold_data_nxt = in_data;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end else if (w_accept) begin
                w_hold_data_nxt = in_data;
                w_hold_full_nxt = 1'b1;
            end
        end else begin
            // Nothing to send: a strobe here is an underrun and is not
            // applied to a word arriving on the same edge
            w_underrun_nxt = next;
            w_cnt_nxt      = '0;
            if (r_hold_full) begin
                w_shift_data_nxt = r_hold_data;
                w_shift_full_nxt = 1'b1;
                w_hold_full_nxt  = 1'b0;
            end else if (w_accept) begin
                w_shift_data_nxt = in_data;
                w_shift_full_nxt = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_data   <= '0;
            r_shift_full   <= 1'b0;
            r_cnt          <= '0;
            r_hold_data    <= '0;
            r_hold_full    <= 1'b0;
            r_symbol       <= '0;
            r_symbol_valid <= 1'b0;
            r_last         <= 1'b0;
            r_underrun     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_shift_data   <= w_shift_data_nxt;
            r_shift_full   <= w_shift_full_nxt;
            r_cnt          <= w_cnt_nxt;
            r_hold_data    <= w_hold_data_nxt;
            r_hold_full    <= w_hold_full_nxt;
            r_symbol       <= w_symbol_nxt;
            r_symbol_valid <= w_symbol_valid_nxt;
            r_last         <= w_last_nxt;
            r_underrun     <= w_underrun_nxt;
            r_busy         <= w_shift_full_nxt | w_hold_full_nxt;
        end
    end

    assign symbol_out   = r_symbol;
    assign symbol_valid = r_symbol_valid;
    assign last         = r_last;
    assign underrun     = r_underrun;
    assign busy         = r_busy;

endmodule

// File: tb/tb_parallel_serializer.sv
// -----------------------------------------------------------------------------
// tb_parallel_serializer
//   Two instances: A is 16-bit / 1 bit per symbol / LSB first, B is
//   8-bit / 2 bits per symbol / MSB first. Expected symbols are queued as
//   words are issued; per-instance monitors pop and compare on symbol_valid.
// -----------------------------------------------------------------------------
module tb_parallel_serializer;

    typedef struct packed {
        logic [1:0] sym;
        logic       lst;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_in_data;
    logic        a_in_valid, a_in_ready, a_next;
    logic [0:0]  a_symbol_out;
    logic        a_symbol_valid, a_last, a_underrun, a_busy;

    logic [7:0]  b_in_data;
    logic        b_in_valid, b_in_ready, b_next;
    logic [1:0]  b_symbol_out;
    logic        b_symbol_valid, b_last, b_underrun, b_busy;

    int checks   = 0;
    int failures = 0;
    int a_valid_cnt = 0;
    int a_under_cnt = 0;

    exp_t qa[$];
    exp_t qb[$];

    int t1_syms[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    parallel_serializer #(.WIDTH(16), .BITS_PER_SYMBOL(1), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .next(a_next), .symbol_out(a_symbol_out), .symbol_valid(a_symbol_valid),
        .last(a_last), .underrun(a_underrun), .busy(a_busy)
    );

    parallel_serializer #(.WIDTH(8), .BITS_PER_SYMBOL(2), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .next(b_next), .symbol_out(b_symbol_out), .symbol_valid(b_symbol_valid),
        .last(b_last), .underrun(b_underrun), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference for instance A: bit i of the word, last on bit 15
    task automatic push_word_a(input logic [15:0] w);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.sym = {1'b0, w[i]};
            e.lst = (i == 15);
            qa.push_back(e);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (a_underrun === 1'b1) a_under_cnt++;
            if (a_symbol_valid === 1'b1) begin
                a_valid_cnt++;
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected: symbol %0d with empty queue at %0t", a_symbol_out, $time);
                end else begin
                    e = qa.pop_front();
                    check("a_symbol", 32'(a_symbol_out), 32'(e.sym));
                    check("a_last", 32'(a_last), 32'(e.lst));
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_symbol_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: symbol %0d with empty queue at %0t", b_symbol_out, $time);
            end else begin
                e = qb.pop_front();
                check("b_symbol", 32'(b_symbol_out), 32'(e.sym));
                check("b_last", 32'(b_last), 32'(e.lst));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int ucnt;
        int vcnt;
        int gaps;
        exp_t e;

        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_next = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_next = 1'b0;

        // Reset state
        #3;
        check("rst_a_ready", 32'(a_in_ready), 0);
        check("rst_a_outs", 32'({a_symbol_out, a_symbol_valid, a_last, a_underrun, a_busy}), 0);
        check("rst_b_outs", 32'({b_in_ready, b_symbol_out, b_symbol_valid, b_last, b_underrun, b_busy}), 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rel_a_ready", 32'(a_in_ready), 1);
        check("rel_a_busy", 32'(a_busy), 0);

        // T1: 0xA5C3, LSB first, strobe every cycle
        for (int i = 0; i < 16; i++) begin
            e.sym = 2'(t1_syms[i]);
            e.lst = (i == 15);
            qa.push_back(e);
        end
        ucnt = a_under_cnt;
        a_in_data = 16'hA5C3; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("t1_busy_loaded", 32'(a_busy), 1);
        a_next = 1'b1;
        for (int i = 0; i < 16; i++) step();
        a_next = 1'b0;
        step(); step();
        check("t1_busy_after", 32'(a_busy), 0);
        check("t1_ready", 32'(a_in_ready), 1);
        check("t1_queue_empty", 32'(qa.size()), 0);
        check("t1_no_underrun", 32'(a_under_cnt - ucnt), 0);

        // T2: 0xFFFF and 0x0000 back to back, gapless
        push_word_a(16'hFFFF);
        push_word_a(16'h0000);
        ucnt = a_under_cnt;
        vcnt = a_valid_cnt;
        gaps = 0;
        a_in_data = 16'hFFFF; a_in_valid = 1'b1;
        step();
        a_in_data = 16'h0000;
        a_next = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i == 0) a_in_valid = 1'b0;
            if (a_symbol_valid !== 1'b1) gaps++;
        end
        a_next = 1'b0;
        step(); step();
        check("t2_gaps", 32'(gaps), 0);
        check("t2_pulses", 32'(a_valid_cnt - vcnt), 32);
        check("t2_no_underrun", 32'(a_under_cnt - ucnt), 0);
        check("t2_queue_empty", 32'(qa.size()), 0);

        // T3: instance B, 0x1B MSB first in 2-bit symbols
        e.sym = 2'b00; e.lst = 1'b0; qb.push_back(e);
        e.sym = 2'b01; e.lst = 1'b0; qb.push_back(e);
        e.sym = 2'b10; e.lst = 1'b0; qb.push_back(e);
        e.sym = 2'b11; e.lst = 1'b1; qb.push_back(e);
        b_in_data = 8'h1B; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_next = 1'b1;
        for (int i = 0; i < 4; i++) step();
        b_next = 1'b0;
        step(); step();
        check("t3_queue_empty", 32'(qb.size()), 0);
        check("t3_busy", 32'(b_busy), 0);
        check("t3_underrun", 32'(b_underrun), 0);

        // T4: backpressure with three words
        push_word_a(16'h1234);
        push_word_a(16'h5678);
        push_word_a(16'h9ABC);
        a_in_data = 16'h1234; a_in_valid = 1'b1;
        step();
        check("t4_ready_w1", 32'(a_in_ready), 1);
        a_in_data = 16'h5678;
        step();
        check("t4_ready_full", 32'(a_in_ready), 0);
        a_in_data = 16'h9ABC;
        step();
        check("t4_ready_held", 32'(a_in_ready), 0);
        a_next = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 14) check("t4_ready_15", 32'(a_in_ready), 0);
        end
        check("t4_ready_16", 32'(a_in_ready), 1);
        a_next = 1'b0;
        step();
        a_in_valid = 1'b0;
        check("t4_ready_w3", 32'(a_in_ready), 0);
        a_next = 1'b1;
        for (int i = 0; i < 32; i++) step();
        a_next = 1'b0;
        step(); step();
        check("t4_queue_empty", 32'(qa.size()), 0);
        check("t4_busy", 32'(a_busy), 0);

        // T5: strobe with no data after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        a_next = 1'b1;
        step();
        check("t5_underrun", 32'(a_underrun), 1);
        check("t5_valid", 32'(a_symbol_valid), 0);
        check("t5_symbol", 32'(a_symbol_out), 0);
        a_next = 1'b0;
        step();
        check("t5_underrun_pulse", 32'(a_underrun), 0);
        push_word_a(16'h0003);
        a_in_data = 16'h0003; a_in_valid = 1'b1; a_next = 1'b1;
        step();
        a_in_valid = 1'b0;
        check("t5_same_edge_underrun", 32'(a_underrun), 1);
        check("t5_same_edge_valid", 32'(a_symbol_valid), 0);
        check("t5_same_edge_busy", 32'(a_busy), 1);
        step();
        check("t5_first_valid", 32'(a_symbol_valid), 1);
        check("t5_first_symbol", 32'(a_symbol_out), 1);
        for (int i = 0; i < 15; i++) step();
        a_next = 1'b0;
        step(); step();
        check("t5_queue_empty", 32'(qa.size()), 0);

        // T6: reset after 5 of 16 symbols with the hold stage full
        e.lst = 1'b0;
        e.sym = 2'd1; qa.push_back(e);
        e.sym = 2'd0;
        for (int i = 0; i < 4; i++) qa.push_back(e);
        a_in_data = 16'h8421; a_in_valid = 1'b1;
        step();
        a_in_data = 16'h1111; a_next = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        a_next = 1'b0;
        check("t6_ready_hold", 32'(a_in_ready), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outs", 32'({a_symbol_out, a_symbol_valid, a_last, a_underrun, a_busy}), 0);
        check("t6_rst_ready", 32'(a_in_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_rel_ready", 32'(a_in_ready), 1);
        check("t6_rel_busy", 32'(a_busy), 0);
        check("t6_queue_drained", 32'(qa.size()), 0);
        push_word_a(16'h0001);
        a_in_data = 16'h0001; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_next = 1'b1;
        step();
        check("t6_fresh_first", 32'(a_symbol_out), 1);
        for (int i = 0; i < 15; i++) step();
        a_next = 1'b0;
        step(); step();
        check("t6_queue_empty", 32'(qa.size()), 0);
        check("t6_busy", 32'(a_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
